// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Start/busy/done handshake; divide-by-zero and signed overflow take a one-cycle fast path.
//
// state | meaning
// IDLE  | waiting for i_start
// CALC  | XLEN shift-subtract iterations
// FIX   | sign correction and quotient/remainder select
// DONE  | o_done pulse, o_result valid; a new start may be accepted
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] b_mag_q;
    logic [CW-1:0]   cnt_q;
    logic            is_rem_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            signed_op;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            borrow;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic            cnt_zero;

    // Operand decode at the capture edge
    always_comb begin
        accept      = i_start && (state_q == IDLE || state_q == DONE);
        signed_op   = ~i_op[0];
        is_rem      = i_op[1];
        a_neg       = signed_op & i_a[XLEN-1];
        b_neg       = signed_op & i_b[XLEN-1];
        a_mag       = a_neg ? (~i_a + 1'b1) : i_a;
        b_mag       = b_neg ? (~i_b + 1'b1) : i_b;
        div_zero    = (i_b == '0);
        overflow    = signed_op && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_b);
        fast        = div_zero || overflow;
        fast_result = '0;
        if (div_zero) begin
            fast_result = is_rem ? i_a : '1;
        end else if (overflow) begin
            fast_result = is_rem ? '0 : i_a;
        end
    end

    // Both top bits of the trial difference flag an out-of-range result:
    // bit XLEN+1 is the true borrow, bit XLEN can only be set alongside it.
    always_comb begin
        shifted  = {rem_q, quot_q[XLEN-1]};
        trial    = {1'b0, shifted} - {2'b00, b_mag_q};
        borrow   = trial[XLEN+1] | trial[XLEN];
        quot_fix = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
        rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        cnt_zero = (cnt_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                if (cnt_zero) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                o_busy  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem_q      <= '0;
            quot_q     <= '0;
            b_mag_q    <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else if (accept) begin
            rem_q      <= '0;
            quot_q     <= a_mag;
            b_mag_q    <= b_mag;
            cnt_q      <= CW'(XLEN - 1);
            is_rem_q   <= is_rem;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            if (fast) begin
                result_q <= fast_result;
            end
        end else if (state_q == CALC) begin
            rem_q  <= borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], ~borrow};
            cnt_q  <= cnt_q - 1'b1;
        end else if (state_q == FIX) begin
            result_q <= is_rem_q ? rem_fix : quot_fix;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a result scoreboard,
// plus hand-written handshake, back-to-back and reset-abort sequences.
module tb_div_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        bit              fast;
    } vec_t;

    vec_t vecs[17];

    div_unit #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one start pulse in cycle 0; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic [XLEN-1:0] e, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = ~y;
    endtask

    task automatic wait_done(input string name, input int c0, input int exp_lat, input int exp_busy);
        int c = c0;
        int bc = 0;
        bit got = 0;
        logic [XLEN-1:0] e;
        while (c <= exp_lat + 20) begin
            if (busy) bc++;
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            c++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, exp_lat + 20);
            return;
        end
        check({name, " latency"}, XLEN'(c), XLEN'(exp_lat));
        check({name, " busy_cycles"}, XLEN'(bc), XLEN'(exp_busy));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({name, " result"}, result, e);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{2'b10, 32'd20,        32'hFFFFFFFD, 32'h00000002, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{2'b01, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 1'b0};
        vecs[4]  = '{2'b11, 32'hFFFFFFFF,  32'd2,        32'h00000001, 1'b0};
        vecs[5]  = '{2'b01, 32'd7,         32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{2'b10, 32'd7,         32'd0,        32'h00000007, 1'b1};
        vecs[7]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[8]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF,  32'h80000001, 32'h00000001, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFF,  32'h80000001, 32'h7FFFFFFE, 1'b0};
        vecs[11] = '{2'b00, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[12] = '{2'b10, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 1'b0};
        vecs[13] = '{2'b00, 32'h80000000,  32'd2,        32'hC0000000, 1'b0};
        vecs[14] = '{2'b00, 32'd7,         32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{2'b10, 32'hFFFFFFF0,  32'd0,        32'hFFFFFFF0, 1'b1};
        vecs[16] = '{2'b01, 32'd0,         32'd5,        32'h00000000, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", XLEN'(busy), '0);
        check("reset done", XLEN'(done), '0);
        check("reset result", result, '0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_done($sformatf("vec%0d", i), 1, vecs[i].fast ? 1 : LAT, vecs[i].fast ? 0 : LAT - 1);
        end

        // Start pulse while busy must be ignored
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", 6, LAT, LAT - 6);

        // Back-to-back: start held in the DONE cycle
        issue(2'b00, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b1);
        repeat (LAT - 1) @(negedge clk);
        check("b2b first done", XLEN'(done), XLEN'(1));
        check("b2b first result", result, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        exp_q.push_back(32'd2);
        @(negedge clk);
        start = 1'b0;
        check("b2b second busy", XLEN'(busy), XLEN'(1));
        check("b2b result held", result, 32'hFFFFFFFA);
        wait_done("b2b second", 1, LAT, LAT - 1);

        // Reset in the middle of an operation
        issue(2'b01, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", XLEN'(busy), '0);
        check("abort done", XLEN'(done), '0);
        check("abort result", result, '0);
        begin
            int dc = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done || busy) dc++;
            end
            check("abort quiet", XLEN'(dc), '0);
        end
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done("after_reset", 1, LAT, LAT - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
